// File: rtl/move_scheduler_if.sv
// move_scheduler_if: buttons, scan position, wall-check handshake and position outputs of the move scheduler
interface move_scheduler_if;
    logic       Up;
    logic       Down;
    logic       Left;
    logic       Right;
    logic       Fire;
    logic       MoveSpeed_1;
    logic       MoveSpeed_0;
    logic [9:0] Val_Row_In;
    logic [9:0] Val_Col_In;
    logic       Check_Ack_In;
    logic       Blocked_In;
    logic       Check_Req_Out;
    logic [4:0] Cand_X_Out;
    logic [4:0] Cand_Y_Out;
    logic [4:0] Pos_X_Out;
    logic [4:0] Pos_Y_Out;
    logic       Frame_Tick_Out;
    logic       Move_Done_Out;
    logic       Fire_Pulse_Out;

    modport master (
        input  Up, Down, Left, Right, Fire, MoveSpeed_1, MoveSpeed_0,
        input  Val_Row_In, Val_Col_In, Check_Ack_In, Blocked_In,
        output Check_Req_Out, Cand_X_Out, Cand_Y_Out, Pos_X_Out, Pos_Y_Out,
        output Frame_Tick_Out, Move_Done_Out, Fire_Pulse_Out
    );

    modport slave (
        output Up, Down, Left, Right, Fire, MoveSpeed_1, MoveSpeed_0,
        output Val_Row_In, Val_Col_In, Check_Ack_In, Blocked_In,
        input  Check_Req_Out, Cand_X_Out, Cand_Y_Out, Pos_X_Out, Pos_Y_Out,
        input  Frame_Tick_Out, Move_Done_Out, Fire_Pulse_Out
    );
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: frame-divided player movement with button priority, wall-check handshake and tile commit
module move_scheduler #(
    parameter int GRID_W      = 32,
    parameter int GRID_H      = 24,
    parameter int START_X     = 1,
    parameter int START_Y     = 1,
    parameter int ACTIVE_ROWS = 480,
    parameter int ACK_TIMEOUT = 64
) (
    input logic Master_Clock_In,
    input logic Reset_N_In,
    move_scheduler_if.master bus
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(ACK_TIMEOUT - 1);
    localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
    localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);
    localparam logic [4:0] X_RST = 5'(START_X);
    localparam logic [4:0] Y_RST = 5'(START_Y);

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;
    state_t state;

    logic [4:0] meta, sync;
    logic fire_q, row_q, tick, req, done, fire_pulse;
    logic [2:0] frame_cnt, lim;
    logic [TW-1:0] tmo;
    logic [4:0] pos_x, pos_y, cand_x, cand_y, nx_x, nx_y;
    logic hit, slot, mv_up, mv_dn, mv_lt, mv_rt, legal;

    // sync bit order: {fire, right, left, down, up}; D-1 is 7 >> speed code
    always_comb begin
        hit   = bus.Val_Row_In == 10'(ACTIVE_ROWS);
        lim   = 3'd7 >> {bus.MoveSpeed_1, bus.MoveSpeed_0};
        slot  = tick && (frame_cnt >= lim);
        mv_up = sync[0];
        mv_dn = !sync[0] && sync[1];
        mv_lt = !sync[0] && !sync[1] && sync[2];
        mv_rt = !sync[0] && !sync[1] && !sync[2] && sync[3];
        nx_x  = mv_lt ? pos_x - 5'd1 : mv_rt ? pos_x + 5'd1 : pos_x;
        nx_y  = mv_up ? pos_y - 5'd1 : mv_dn ? pos_y + 5'd1 : pos_y;
        legal = mv_up ? pos_y != 5'd0 : mv_dn ? pos_y != Y_MAX :
                mv_lt ? pos_x != 5'd0 : mv_rt ? pos_x != X_MAX : 1'b0;
    end

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            meta       <= '0;
            sync       <= '0;
            fire_q     <= 1'b0;
            fire_pulse <= 1'b0;
            row_q      <= 1'b0;
            tick       <= 1'b0;
            frame_cnt  <= '0;
            tmo        <= '0;
            state      <= IDLE;
            req        <= 1'b0;
            done       <= 1'b0;
            pos_x      <= X_RST;
            pos_y      <= Y_RST;
            cand_x     <= X_RST;
            cand_y     <= Y_RST;
        end else begin
            meta       <= {bus.Fire, bus.Right, bus.Left, bus.Down, bus.Up};
            sync       <= meta;
            fire_q     <= sync[4];
            fire_pulse <= sync[4] && !fire_q;
            row_q      <= hit;
            tick       <= hit && !row_q;
            done       <= 1'b0;
            if (tick) frame_cnt <= slot ? 3'd0 : frame_cnt + 3'd1;
            // slots arriving outside IDLE are simply lost
            case (state)
                IDLE: if (slot && legal) begin
                    cand_x <= nx_x;
                    cand_y <= nx_y;
                    tmo    <= '0;
                    req    <= 1'b1;
                    state  <= CHECK;
                end
                CHECK: if (bus.Check_Ack_In) begin
                    req   <= 1'b0;
                    state <= bus.Blocked_In ? IDLE : COMMIT;
                end else if (tmo == T_MAX) begin
                    req   <= 1'b0;
                    state <= IDLE;
                end else tmo <= tmo + 1'b1;
                COMMIT: begin
                    pos_x <= cand_x;
                    pos_y <= cand_y;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Check_Req_Out  = req;
    assign bus.Cand_X_Out     = cand_x;
    assign bus.Cand_Y_Out     = cand_y;
    assign bus.Pos_X_Out      = pos_x;
    assign bus.Pos_Y_Out      = pos_y;
    assign bus.Frame_Tick_Out = tick;
    assign bus.Move_Done_Out  = done;
    assign bus.Fire_Pulse_Out = fire_pulse;
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: vector table plus commit scoreboard for move_scheduler
module tb_move_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ack_en = 1'b0;
    logic blk_en = 1'b0;
    int total = 0;
    int bad = 0;
    int req_cyc = 0;
    int done_cnt = 0;
    int tick_cnt = 0;
    int fire_cnt = 0;
    int sb[$];

    move_scheduler_if mif();

    move_scheduler dut (
        .Master_Clock_In(clk),
        .Reset_N_In(rst_n),
        .bus(mif)
    );

    always #20 clk = ~clk;

    assign mif.Check_Ack_In = mif.Check_Req_Out & ack_en;
    assign mif.Blocked_In   = blk_en;

    typedef struct {
        logic [3:0] btn;
        logic ack;
        logic blk;
        int ex;
        int ey;
        int done;
        int req;
    } vec_t;

    vec_t vt[18];

    function automatic void check(string n, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", n, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (mif.Check_Req_Out) req_cyc++;
        if (mif.Frame_Tick_Out) tick_cnt++;
        if (mif.Fire_Pulse_Out) fire_cnt++;
        if (mif.Move_Done_Out) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL commit_unexpected pos=(%0d,%0d)", mif.Pos_X_Out, mif.Pos_Y_Out);
            end else
                check("commit_pos", int'(mif.Pos_X_Out) * 32 + int'(mif.Pos_Y_Out), sb.pop_front());
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(logic [3:0] b);
        {mif.Right, mif.Left, mif.Down, mif.Up} = b;
    endtask

    task automatic frame(int hold);
        mif.Val_Row_In = 10'd480;
        cyc(hold);
        mif.Val_Row_In = 10'd0;
        cyc(100);
    endtask

    initial begin
        int t0;
        bit seen;
        set_btn(4'b0000);
        mif.Fire = 1'b0;
        mif.MoveSpeed_1 = 1'b1;
        mif.MoveSpeed_0 = 1'b1;
        mif.Val_Row_In = 10'd0;
        mif.Val_Col_In = 10'd0;
        // btn = {right, left, down, up}
        vt[0]  = '{4'b1000, 1'b1, 1'b0, 2, 1, 1, 1};
        vt[1]  = '{4'b1000, 1'b1, 1'b0, 3, 1, 1, 1};
        vt[2]  = '{4'b1000, 1'b1, 1'b0, 4, 1, 1, 1};
        vt[3]  = '{4'b0010, 1'b1, 1'b0, 4, 2, 1, 1};
        vt[4]  = '{4'b0101, 1'b1, 1'b0, 4, 1, 1, 1};
        vt[5]  = '{4'b0100, 1'b1, 1'b0, 3, 1, 1, 1};
        vt[6]  = '{4'b1000, 1'b1, 1'b1, 3, 1, 0, 1};
        vt[7]  = '{4'b0000, 1'b1, 1'b0, 3, 1, 0, 0};
        vt[8]  = '{4'b0001, 1'b0, 1'b0, 3, 1, 0, 64};
        vt[9]  = '{4'b0011, 1'b1, 1'b0, 3, 0, 1, 1};
        vt[10] = '{4'b0001, 1'b1, 1'b0, 3, 0, 0, 0};
        vt[11] = '{4'b1010, 1'b1, 1'b0, 3, 1, 1, 1};
        vt[12] = '{4'b0001, 1'b1, 1'b0, 3, 0, 1, 1};
        vt[13] = '{4'b0100, 1'b1, 1'b0, 2, 0, 1, 1};
        vt[14] = '{4'b0100, 1'b1, 1'b0, 1, 0, 1, 1};
        vt[15] = '{4'b0100, 1'b1, 1'b0, 0, 0, 1, 1};
        vt[16] = '{4'b0100, 1'b1, 1'b0, 0, 0, 0, 0};
        vt[17] = '{4'b0010, 1'b1, 1'b1, 0, 0, 0, 1};

        cyc(3);
        check("rst_posx", mif.Pos_X_Out, 1);
        check("rst_posy", mif.Pos_Y_Out, 1);
        check("rst_candx", mif.Cand_X_Out, 1);
        check("rst_req", mif.Check_Req_Out, 0);
        check("rst_pulses", {mif.Move_Done_Out, mif.Frame_Tick_Out, mif.Fire_Pulse_Out}, 0);
        rst_n = 1'b1;
        cyc(3);

        for (int i = 0; i < 18; i++) begin
            set_btn(vt[i].btn);
            ack_en = vt[i].ack;
            blk_en = vt[i].blk;
            cyc(4);
            if (vt[i].done != 0) sb.push_back(vt[i].ex * 32 + vt[i].ey);
            req_cyc = 0;
            done_cnt = 0;
            frame(10);
            check($sformatf("v%0d_posx", i), mif.Pos_X_Out, vt[i].ex);
            check($sformatf("v%0d_posy", i), mif.Pos_Y_Out, vt[i].ey);
            check($sformatf("v%0d_done", i), done_cnt, vt[i].done);
            check($sformatf("v%0d_reqcyc", i), req_cyc, vt[i].req);
        end

        set_btn(4'b0010);
        blk_en = 1'b0;
        ack_en = 1'b1;
        cyc(4);
        for (int y = 1; y <= 23; y++) begin
            sb.push_back(y);
            frame(4);
        end
        check("down_run_posy", mif.Pos_Y_Out, 23);
        req_cyc = 0;
        frame(4);
        check("bottom_edge_req", req_cyc, 0);
        check("bottom_edge_posy", mif.Pos_Y_Out, 23);

        mif.MoveSpeed_1 = 1'b0;
        mif.MoveSpeed_0 = 1'b0;
        set_btn(4'b1000);
        cyc(4);
        for (int t = 1; t <= 16; t++) begin
            if (t == 8 || t == 16) sb.push_back((t / 8) * 32 + 23);
            frame(3);
            if (t == 7) check("slow_t7_posx", mif.Pos_X_Out, 0);
            if (t == 8) check("slow_t8_posx", mif.Pos_X_Out, 1);
            if (t == 15) check("slow_t15_posx", mif.Pos_X_Out, 1);
        end
        check("slow_t16_posx", mif.Pos_X_Out, 2);

        set_btn(4'b0000);
        tick_cnt = 0;
        mif.Val_Row_In = 10'd480;
        cyc(800);
        mif.Val_Row_In = 10'd0;
        cyc(5);
        check("row_hold_ticks", tick_cnt, 1);

        fire_cnt = 0;
        mif.Fire = 1'b1;
        cyc(1000);
        check("fire_hold_pulses", fire_cnt, 1);
        mif.Fire = 1'b0;
        cyc(10);
        mif.Fire = 1'b1;
        cyc(5);
        mif.Fire = 1'b0;
        cyc(5);
        check("fire_second_press", fire_cnt, 2);

        mif.MoveSpeed_1 = 1'b1;
        mif.MoveSpeed_0 = 1'b1;
        set_btn(4'b1000);
        ack_en = 1'b0;
        cyc(4);
        mif.Val_Row_In = 10'd480;
        seen = 1'b0;
        t0 = 0;
        while (!seen && t0 < 20) begin
            cyc(1);
            t0++;
            seen = mif.Check_Req_Out;
        end
        mif.Val_Row_In = 10'd0;
        check("rst_test_req_seen", int'(seen), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", mif.Check_Req_Out, 0);
        check("async_rst_pos", int'(mif.Pos_X_Out) * 32 + int'(mif.Pos_Y_Out), 33);
        cyc(3);
        rst_n = 1'b1;
        ack_en = 1'b1;
        req_cyc = 0;
        done_cnt = 0;
        cyc(100);
        check("post_rst_done", done_cnt, 0);
        check("post_rst_req", req_cyc, 0);
        check("post_rst_pos", int'(mif.Pos_X_Out) * 32 + int'(mif.Pos_Y_Out), 33);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
